// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Which source produced the next PC
    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_BR  = 2'd1,
        SRC_JMP = 2'd2,
        SRC_JR  = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target formation for the fetch unit.
// Computes branch / jump / register-jump targets, applies the fixed
// priority jr > jmp > br, and rejects misaligned JR targets.
// Ports:
//   i_redir_base_pc  PC of the branch/jump instruction
//   i_br_taken, i_br_offset_sh     branch request and pre-shifted offset
//   i_jmp_valid, i_jmp_target_sh   J/JAL request and shifted target
//   i_jr_valid, i_jr_target        JR/JALR request and register target
//   o_target_c       selected redirect target
//   o_src_c          selected source (SRC_SEQ when no redirect applies)
//   o_misalign_c     JR requested with a non word-aligned target
module pc_target_calc
    import mips_pkg::*;
#(
    parameter int unsigned JT_LEN = 28
) (
    input  logic [31:0]       i_redir_base_pc,
    input  logic              i_br_taken,
    input  logic [31:0]       i_br_offset_sh,
    input  logic              i_jmp_valid,
    input  logic [JT_LEN-1:0] i_jmp_target_sh,
    input  logic              i_jr_valid,
    input  logic [31:0]       i_jr_target,
    output logic [31:0]       o_target_c,
    output redir_src_e        o_src_c,
    output logic              o_misalign_c
);

    logic [31:0] w_seq_pc;

    assign w_seq_pc = i_redir_base_pc + 32'(INSTR_BYTES);

    // A misaligned JR suppresses every redirect source in that cycle
    always_comb begin
        o_target_c   = 32'h0;
        o_src_c      = SRC_SEQ;
        o_misalign_c = 1'b0;
        if (i_jr_valid) begin
            if (i_jr_target[1:0] != 2'b00) begin
                o_misalign_c = 1'b1;
            end else begin
                o_src_c    = SRC_JR;
                o_target_c = i_jr_target;
            end
        end else if (i_jmp_valid) begin
            o_src_c    = SRC_JMP;
            o_target_c = {w_seq_pc[31:JT_LEN], i_jmp_target_sh};
        end else if (i_br_taken) begin
            o_src_c    = SRC_BR;
            o_target_c = w_seq_pc + i_br_offset_sh;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Issues one imem request at a time, buffers the returned word for
// decode behind a valid/ready handshake, and applies branch/jump/JR
// redirects, discarding any word fetched down the stale path.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_req/addr/ready            fetch request channel
//   imem_rvalid/rdata              fetch response channel
//   instr_valid/instr/instr_pc/instr_ready   decode handshake
//   redir_base_pc, br_*, jmp_*, jr_*         redirect inputs
//   misalign_err                   one-cycle pulse on a rejected JR
module pc_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned JT_LEN   = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    input  logic              instr_ready,
    input  logic [31:0]       redir_base_pc,
    input  logic              br_taken,
    input  logic [31:0]       br_offset_sh,
    input  logic              jmp_valid,
    input  logic [JT_LEN-1:0] jmp_target_sh,
    input  logic              jr_valid,
    input  logic [31:0]       jr_target,
    output logic              misalign_err
);

    localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_pc;
    logic         r_drop;

    logic [31:0]  w_target;
    redir_src_e   w_src;
    logic         w_misalign;
    logic         w_redir;
    logic [31:0]  w_next_pc;

    pc_target_calc #(
        .JT_LEN (JT_LEN)
    ) u_target_calc (
        .i_redir_base_pc (redir_base_pc),
        .i_br_taken      (br_taken),
        .i_br_offset_sh  (br_offset_sh),
        .i_jmp_valid     (jmp_valid),
        .i_jmp_target_sh (jmp_target_sh),
        .i_jr_valid      (jr_valid),
        .i_jr_target     (jr_target),
        .o_target_c      (w_target),
        .o_src_c         (w_src),
        .o_misalign_c    (w_misalign)
    );

    assign w_redir   = (w_src != SRC_SEQ);
    assign w_next_pc = w_redir ? w_target : r_pc;

    // Fetch FSM; r_drop marks the outstanding response as stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 32'h0;
            r_drop       <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= 32'h0;
            instr_pc     <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= w_misalign;
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= w_next_pc;
                    r_pc      <= w_next_pc;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        r_state    <= ST_WAIT;
                        imem_req   <= 1'b0;
                        r_fetch_pc <= imem_addr;
                        if (w_redir) begin
                            r_pc   <= w_target;
                            r_drop <= 1'b1;
                        end else if (!r_drop) begin
                            r_pc <= r_pc + PC_STEP;
                        end
                    end else if (w_redir) begin
                        // Old address stays on the bus; its word will be dropped
                        r_pc   <= w_target;
                        r_drop <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop || w_redir) begin
                            r_drop    <= 1'b0;
                            r_state   <= ST_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= w_next_pc;
                            r_pc      <= w_next_pc;
                        end else begin
                            r_state     <= ST_HOLD;
                            instr       <= imem_rdata;
                            instr_pc    <= r_fetch_pc;
                            instr_valid <= 1'b1;
                        end
                    end else if (w_redir) begin
                        r_pc   <= w_target;
                        r_drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready || w_redir) begin
                        r_state     <= ST_REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= w_next_pc;
                        r_pc        <= w_next_pc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small latency-configurable
// instruction memory model. A second instance starts at 0xFFFF_FFFC.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] redir_base_pc;
    logic        br_taken;
    logic [31:0] br_offset_sh;
    logic        jmp_valid;
    logic [27:0] jmp_target_sh;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        misalign_err;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_misalign_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        seen_valid = 1'b0;

    pc_fetch_ctrl dut (
        .clk (clk), .rst_n (rst_n),
        .imem_req (imem_req), .imem_addr (imem_addr), .imem_ready (imem_ready),
        .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
        .instr_valid (instr_valid), .instr (instr), .instr_pc (instr_pc),
        .instr_ready (instr_ready), .redir_base_pc (redir_base_pc),
        .br_taken (br_taken), .br_offset_sh (br_offset_sh),
        .jmp_valid (jmp_valid), .jmp_target_sh (jmp_target_sh),
        .jr_valid (jr_valid), .jr_target (jr_target),
        .misalign_err (misalign_err)
    );

    pc_fetch_ctrl #(.RESET_PC (32'hFFFF_FFFC)) dut_wrap (
        .clk (clk), .rst_n (rst_n),
        .imem_req (w_imem_req), .imem_addr (w_imem_addr), .imem_ready (imem_ready),
        .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
        .instr_valid (w_instr_valid), .instr (w_instr), .instr_pc (w_instr_pc),
        .instr_ready (instr_ready), .redir_base_pc (redir_base_pc),
        .br_taken (br_taken), .br_offset_sh (br_offset_sh),
        .jmp_valid (jmp_valid), .jmp_target_sh (jmp_target_sh),
        .jr_valid (jr_valid), .jr_target (jr_target),
        .misalign_err (w_misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (instr_valid) seen_valid = 1'b1;
        end while (!imem_req && n < max);
        if (!imem_req) check_eq("req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic wait_ivalid(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < max);
        if (!instr_valid) check_eq("ivalid_timeout", 32'(instr_valid), 32'd1);
    endtask

    // Memory: response imem_lat cycles after acceptance; unaware of DUT reset
    initial begin : mem_model
        logic        acc;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            acc = imem_req && imem_ready;
            a   = imem_addr;
            #1;
            imem_rvalid = 1'b0;
            if (acc) begin
                pend_addr = a;
                pend_cnt  = mem_lat;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                end
            end
        end
    end

    initial begin : stim
        int n;
        logic [31:0] held_instr;
        rst_n = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1;
        redir_base_pc = 32'h0; br_taken = 1'b0; br_offset_sh = 32'h0;
        jmp_valid = 1'b0; jmp_target_sh = 28'h0; jr_valid = 1'b0; jr_target = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_req",   32'(imem_req), 32'd0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_ivld",  32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_ipc",   instr_pc, 32'h0);
        check_eq("rst_mis",   32'(misalign_err), 32'd0);
        check_eq("rst_waddr", w_imem_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // Sequential fetch 0x0, 0x4, 0x8; wrap instance goes FFFFFFFC -> 0
        for (int k = 0; k < 3; k++) begin
            wait_req(10, n);
            if (k == 0) check_eq("first_req_lat", 32'(n), 32'd1);
            check_eq("seq_addr", imem_addr, 32'(4 * k));
            if (k == 0) check_eq("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
            if (k == 1) check_eq("wrap_addr1", w_imem_addr, 32'h0000_0000);
            wait_ivalid(10, n);
            check_eq("req_to_valid", 32'(n), 32'd2);
            check_eq("seq_ipc",   instr_pc, 32'(4 * k));
            check_eq("seq_instr", instr, mem_word(32'(4 * k)));
        end

        // Decode back-pressure in HOLD
        wait_req(10, n);
        check_eq("bp_addr", imem_addr, 32'hC);
        instr_ready = 1'b0;
        wait_ivalid(10, n);
        held_instr = instr;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp_ivld",  32'(instr_valid), 32'd1);
            check_eq("bp_instr", instr, held_instr);
            check_eq("bp_ipc",   instr_pc, 32'hC);
            check_eq("bp_req",   32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rel_ivld", 32'(instr_valid), 32'd0);
        check_eq("bp_rel_req",  32'(imem_req), 32'd1);
        check_eq("bp_rel_addr", imem_addr, 32'h10);

        // Jump while WAIT: in-flight word for 0x10 dropped
        mem_lat = 3;
        @(negedge clk);
        check_eq("jw_req_low", 32'(imem_req), 32'd0);
        jmp_valid = 1'b1; redir_base_pc = 32'h4000_0010; jmp_target_sh = 28'h000_0100;
        mem_lat = 1;
        seen_valid = 1'b0;
        @(negedge clk);
        jmp_valid = 1'b0;
        if (instr_valid) seen_valid = 1'b1;
        wait_req(10, n);
        check_eq("jw_addr",   imem_addr, 32'h4000_0100);
        check_eq("jw_nodrop", 32'(seen_valid), 32'd0);
        wait_ivalid(10, n);
        check_eq("jw_ipc",   instr_pc, 32'h4000_0100);
        check_eq("jw_instr", instr, mem_word(32'h4000_0100));

        // Branch in HOLD with instr_ready=1: 0x20 + 4 - 32 = 0x4
        br_taken = 1'b1; redir_base_pc = 32'h20; br_offset_sh = 32'hFFFF_FFE0;
        @(negedge clk);
        br_taken = 1'b0;
        check_eq("br_req",  32'(imem_req), 32'd1);
        check_eq("br_addr", imem_addr, 32'h4);
        check_eq("br_ivld", 32'(instr_valid), 32'd0);
        wait_ivalid(10, n);
        check_eq("br_ipc", instr_pc, 32'h4);

        // JR beats a simultaneous branch
        jr_valid = 1'b1; jr_target = 32'h200;
        br_taken = 1'b1; redir_base_pc = 32'h20; br_offset_sh = 32'h40;
        @(negedge clk);
        jr_valid = 1'b0; br_taken = 1'b0;
        check_eq("jrpri_addr", imem_addr, 32'h200);
        wait_ivalid(10, n);
        check_eq("jrpri_ipc", instr_pc, 32'h200);

        // Misaligned JR: pulse, redirect (and branch) ignored
        jr_valid = 1'b1; jr_target = 32'h102; br_taken = 1'b1;
        @(negedge clk);
        jr_valid = 1'b0; br_taken = 1'b0;
        check_eq("mis_pulse", 32'(misalign_err), 32'd1);
        check_eq("mis_addr",  imem_addr, 32'h204);
        check_eq("mis_req",   32'(imem_req), 32'd1);
        mem_lat = 4;
        @(negedge clk);
        check_eq("mis_once",  32'(misalign_err), 32'd0);
        check_eq("wait_req0", 32'(imem_req), 32'd0);

        // Async reset mid-WAIT
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req",   32'(imem_req), 32'd0);
        check_eq("arst_addr",  imem_addr, 32'h0);
        check_eq("arst_ivld",  32'(instr_valid), 32'd0);
        check_eq("arst_instr", instr, 32'h0);
        check_eq("arst_ipc",   instr_pc, 32'h0);
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_req1",  32'(imem_req), 32'd1);
        check_eq("arst_addr1", imem_addr, 32'h0);
        // Redirect while the request is stalled; late response arrives meanwhile
        jr_valid = 1'b1; jr_target = 32'h300;
        @(negedge clk);
        jr_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_eq("stall_addr", imem_addr, 32'h0);
            check_eq("stall_req",  32'(imem_req), 32'd1);
            check_eq("late_rv_ign", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        imem_ready = 1'b1;
        mem_lat = 1;
        seen_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_acc", 32'(imem_req), 32'd0);
        wait_req(10, n);
        check_eq("redir_stall_addr", imem_addr, 32'h300);
        check_eq("redir_stall_drop", 32'(seen_valid), 32'd0);
        wait_ivalid(10, n);
        check_eq("final_ipc",   instr_pc, 32'h300);
        check_eq("final_instr", instr, mem_word(32'h300));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
